// File: rtl/cam_field_lock_monitor.sv
// Per-field line/period measurement and input lock state machine for the camera stream.
// Optional build macro FIELD_LOCK_PERIOD_CHECK_EN adds the period tolerance to the good-field test.
module cam_field_lock_monitor #(
    parameter int NOMINAL_LINES  = 262,
    parameter int LINE_TOL       = 2,
    parameter int NOMINAL_PERIOD = 450450,
    parameter int PERIOD_TOL     = 2000,
    parameter int LOCK_FIELDS    = 4,
    parameter int LOSE_FIELDS    = 3,
    parameter int TIMEOUT_CLKS   = 1080000
) (
    input  logic        cam_pclk,
    input  logic        cam_reset,
    input  logic        cam_line_valid,
    input  logic        cam_field_toggle,
    input  logic        clear,
    output logic        field_new,
    output logic [9:0]  lines_last,
    output logic [23:0] period_last,
    output logic [9:0]  lines_min,
    output logic [9:0]  lines_max,
    output logic [15:0] bad_field_cnt,
    output logic        locked,
    output logic [15:0] status16
);

    typedef enum logic [1:0] {
        ST_UNLOCKED = 2'd0,
        ST_ACQUIRE  = 2'd1,
        ST_LOCKED   = 2'd2,
        ST_HOLDOVER = 2'd3
    } state_t;

    localparam int          LINES_LO   = NOMINAL_LINES - LINE_TOL;
    localparam int          LINES_HI   = NOMINAL_LINES + LINE_TOL;
    localparam int          PERIOD_LO  = NOMINAL_PERIOD - PERIOD_TOL;
    localparam int          PERIOD_HI  = NOMINAL_PERIOD + PERIOD_TOL;
    localparam logic [3:0]  LOCK_N     = 4'(LOCK_FIELDS);
    localparam logic [3:0]  LOSE_N     = 4'(LOSE_FIELDS);
    localparam logic [23:0] TIMEOUT_24 = 24'(TIMEOUT_CLKS);

    state_t      state_q, state_d;
    logic [3:0]  good_run_q, good_run_d;
    logic [3:0]  bad_run_q, bad_run_d;
    logic        field_tgl_q, field_tgl_d;
    logic        lv_q, lv_d;
    logic [9:0]  line_cnt_q, line_cnt_d;
    logic [23:0] period_cnt_q, period_cnt_d;
    logic        armed_q, armed_d;
    logic        field_new_q, field_new_d;
    logic [9:0]  lines_last_q, lines_last_d;
    logic [23:0] period_last_q, period_last_d;
    logic [9:0]  lines_min_q, lines_min_d;
    logic [9:0]  lines_max_q, lines_max_d;
    logic [15:0] bad_cnt_q, bad_cnt_d;
    logic        timeout_flag_q, timeout_flag_d;
    logic        last_good_q, last_good_d;

    logic        field_edge;
    logic        line_rise;
    logic        latch;
    logic        timeout_hit;
    logic        line_ok;
    logic        period_ok;
    logic        field_good;
    logic signed [31:0] lines_s;
    logic signed [31:0] period_s;

    assign field_edge  = cam_field_toggle ^ field_tgl_q;
    assign line_rise   = cam_line_valid & ~lv_q;
    assign latch       = field_edge & armed_q;
    assign timeout_hit = ~field_edge & (period_cnt_q == TIMEOUT_24);

    // Counter values at the edge describe the field that just ended.
    assign lines_s   = $signed({22'd0, line_cnt_q});
    assign period_s  = $signed({8'd0, period_cnt_q});
    assign line_ok   = (lines_s >= LINES_LO) && (lines_s <= LINES_HI);
    assign period_ok = (period_s >= PERIOD_LO) && (period_s <= PERIOD_HI);

`ifdef FIELD_LOCK_PERIOD_CHECK_EN
    assign field_good = line_ok & period_ok;
`else
    // Period window is still evaluated but never gates the decision in this build.
    assign field_good = line_ok | (period_ok & 1'b0);
`endif

    always_comb begin
        field_tgl_d    = cam_field_toggle;
        lv_d           = cam_line_valid;
        line_cnt_d     = line_cnt_q;
        period_cnt_d   = period_cnt_q;
        armed_d        = armed_q;
        field_new_d    = latch;
        lines_last_d   = lines_last_q;
        period_last_d  = period_last_q;
        lines_min_d    = lines_min_q;
        lines_max_d    = lines_max_q;
        bad_cnt_d      = bad_cnt_q;
        timeout_flag_d = timeout_flag_q;
        last_good_d    = last_good_q;

        if (field_edge) begin
            line_cnt_d = line_rise ? 10'd1 : '0;
        end else if (line_rise && (line_cnt_q != '1)) begin
            line_cnt_d = line_cnt_q + 10'd1;
        end

        if (field_edge) begin
            period_cnt_d = 24'd1;
        end else if (period_cnt_q != '1) begin
            period_cnt_d = period_cnt_q + 24'd1;
        end

        if (field_edge) begin
            armed_d = 1'b1;
        end else if (timeout_hit) begin
            armed_d = 1'b0;
        end

        if (clear) begin
            timeout_flag_d = 1'b0;
        end
        if (timeout_hit) begin
            timeout_flag_d = 1'b1;
        end

        // Clear first, so a field latched in the same cycle lands on fresh statistics.
        if (clear) begin
            lines_min_d = '1;
            lines_max_d = '0;
            bad_cnt_d   = '0;
        end
        if (latch) begin
            lines_last_d  = line_cnt_q;
            period_last_d = period_cnt_q;
            last_good_d   = field_good;
            if (line_cnt_q < lines_min_d) begin
                lines_min_d = line_cnt_q;
            end
            if (line_cnt_q > lines_max_d) begin
                lines_max_d = line_cnt_q;
            end
            if (!field_good && (bad_cnt_d != '1)) begin
                bad_cnt_d = bad_cnt_d + 16'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        good_run_d = good_run_q;
        bad_run_d  = bad_run_q;

        if (latch) begin
            case (state_q)
                ST_UNLOCKED: begin
                    if (field_good) begin
                        if (LOCK_N == 4'd1) begin
                            state_d    = ST_LOCKED;
                            good_run_d = '0;
                        end else begin
                            state_d    = ST_ACQUIRE;
                            good_run_d = 4'd1;
                        end
                        bad_run_d = '0;
                    end
                end
                ST_ACQUIRE: begin
                    if (field_good) begin
                        if (good_run_q + 4'd1 == LOCK_N) begin
                            state_d    = ST_LOCKED;
                            good_run_d = '0;
                        end else begin
                            good_run_d = good_run_q + 4'd1;
                        end
                    end else begin
                        state_d    = ST_UNLOCKED;
                        good_run_d = '0;
                    end
                end
                ST_LOCKED: begin
                    if (!field_good) begin
                        if (LOSE_N == 4'd1) begin
                            state_d   = ST_UNLOCKED;
                            bad_run_d = '0;
                        end else begin
                            state_d   = ST_HOLDOVER;
                            bad_run_d = 4'd1;
                        end
                        good_run_d = '0;
                    end
                end
                ST_HOLDOVER: begin
                    if (field_good) begin
                        state_d   = ST_LOCKED;
                        bad_run_d = '0;
                    end else if (bad_run_q + 4'd1 == LOSE_N) begin
                        state_d   = ST_UNLOCKED;
                        bad_run_d = '0;
                    end else begin
                        bad_run_d = bad_run_q + 4'd1;
                    end
                end
                default: begin
                    state_d = ST_UNLOCKED;
                end
            endcase
        end else if (timeout_hit) begin
            state_d    = ST_UNLOCKED;
            good_run_d = '0;
            bad_run_d  = '0;
        end
    end

    always_ff @(posedge cam_pclk or posedge cam_reset) begin
        if (cam_reset) begin
            state_q        <= ST_UNLOCKED;
            good_run_q     <= '0;
            bad_run_q      <= '0;
            field_tgl_q    <= 1'b0;
            lv_q           <= 1'b0;
            line_cnt_q     <= '0;
            period_cnt_q   <= '0;
            armed_q        <= 1'b0;
            field_new_q    <= 1'b0;
            lines_last_q   <= '0;
            period_last_q  <= '0;
            lines_min_q    <= '1;
            lines_max_q    <= '0;
            bad_cnt_q      <= '0;
            timeout_flag_q <= 1'b0;
            last_good_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            good_run_q     <= good_run_d;
            bad_run_q      <= bad_run_d;
            field_tgl_q    <= field_tgl_d;
            lv_q           <= lv_d;
            line_cnt_q     <= line_cnt_d;
            period_cnt_q   <= period_cnt_d;
            armed_q        <= armed_d;
            field_new_q    <= field_new_d;
            lines_last_q   <= lines_last_d;
            period_last_q  <= period_last_d;
            lines_min_q    <= lines_min_d;
            lines_max_q    <= lines_max_d;
            bad_cnt_q      <= bad_cnt_d;
            timeout_flag_q <= timeout_flag_d;
            last_good_q    <= last_good_d;
        end
    end

    assign field_new     = field_new_q;
    assign lines_last    = lines_last_q;
    assign period_last   = period_last_q;
    assign lines_min     = lines_min_q;
    assign lines_max     = lines_max_q;
    assign bad_field_cnt = bad_cnt_q;
    assign locked        = state_q[1];
    assign status16      = {10'd0, armed_q, last_good_q, timeout_flag_q, state_q[1], state_q};

endmodule
